varredura_display: RTL
======================

Name: varredura_display

Overview:
- Scan controller for the Pong LED-matrix datapath.
- Sequences the 5-way position multiplexer through its five slots: top-paddle row, top-paddle row+1, ball, bottom-paddle row, bottom-paddle row+1.
- For each slot it drives the mux selector and the one-hot matrix line enable, inserting a blanking gap between slots to prevent ghosting.
- Emits a one-cycle frame-end pulse so game logic updates positions only between frames.

Parameters:
- DWELL_CICLOS, 1000, clock cycles a slot stays lit (ACTIVE phase); must be ≥1.
- BLANK_CICLOS, 16, clock cycles of blanking before each slot; must be ≥1.
- LINHA_CIMA, 0, matrix line index (0–7) lit for slots 0 and 1.
- LINHA_BAIXO, 7, matrix line index (0–7) lit for slots 3 and 4.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- habilita  in  1  scan enable; low stops scanning and blanks the matrix.
- posy  in  3  ball line index; sampled once per frame (see Behaviour).
- seletor_mux  out  3  slot select to the position mux; values 0–4 only.
- linha  out  8  one-hot line enable; all zeros while blanked.
- apagado  out  1  high whenever linha == 0.
- frame_fim  out  1  one-cycle pulse at the end of slot 4's ACTIVE phase.

Behaviour:
- Reset (async, rst_n low): state=IDLE, slot=0, counter=0, posy_reg=0, seletor_mux=0, linha=0, apagado=1, frame_fim=0. All outputs are registered.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - linha=0, slot=0.
  - habilita=1 → BLANK with counter=0.
- BLANK:
  - linha=0; seletor_mux=slot, driven for the whole phase so the mux output settles before lighting.
  - Counts BLANK_CICLOS cycles, then → ACTIVE with counter=0.
  - On entering BLANK for slot 2, posy_reg <= posy. This is the only posy sample per frame; posy changes mid-frame have no effect until the next frame's slot 2.
- ACTIVE:
  - linha = one-hot of LINHA_CIMA for slots 0/1, posy_reg for slot 2, LINHA_BAIXO for slots 3/4.
  - After DWELL_CICLOS cycles, on the last ACTIVE cycle:
    - slot 4: frame_fim=1 for exactly that cycle; slot wraps to 0.
    - otherwise: slot increments.
  - Then → BLANK, or → IDLE if habilita=0.
- habilita deasserted:
  - In BLANK: → IDLE on the next edge, slot reset to 0, no frame_fim.
  - In ACTIVE: the current dwell completes (no truncated lit slot), then → IDLE, slot reset to 0. frame_fim still fires if the completing slot is 4.
- Frame period: 5·(BLANK_CICLOS+DWELL_CICLOS) cycles. linha is lit 5·DWELL_CICLOS of them.
- Counter:
  - Width $clog2(max(DWELL_CICLOS,BLANK_CICLOS)+1).
  - Compare against value−1; no overflow possible.
- seletor_mux never takes values 5–7.
- linha has at most one bit set at any time.
- apagado == (linha == 0) on every cycle.
- Async reset mid-frame: all outputs return to reset values immediately, not waiting for a clock edge. Scanning restarts from slot 0 BLANK on the first edge after release with habilita=1.

Test Plan:
- Reset release with habilita=1, DWELL=4, BLANK=2, LINHA_CIMA=0, LINHA_BAIXO=7, posy=3 → seletor_mux sequence 0,1,2,3,4,0 and linha pattern: 2 cycles 0x00, then 4 cycles lit per slot in order 0x01, 0x01, 0x08, 0x80, 0x80. frame_fim high only on cycle 30 after the first BLANK entry; period 30.
- posy changes from 3 to 5 during slot 3 → the next frame's slot 2 lights 0x20. The current frame is unaffected.
- posy changes to 6 during slot 2 ACTIVE → linha stays 0x08 for that slot.
- habilita dropped on the 2nd cycle of slot 1 ACTIVE → slot 1 stays lit for all 4 cycles, then linha=0, apagado=1, seletor_mux=0, no frame_fim.
- habilita dropped during slot 4 ACTIVE → frame_fim pulses once at dwell end, then IDLE.
- rst_n pulsed low mid-ACTIVE → linha=0, seletor_mux=0, frame_fim=0 asynchronously, before the next clk edge. The next frame starts at slot 0 BLANK.

Source files
------------

// File: rtl/varredura_display.sv
// Scan controller for the Pong LED matrix: walks the position mux through five slots,
// blanking the matrix before each slot and pulsing frame_fim at the end of every frame.
module varredura_display #(
  parameter int DWELL_CICLOS = 1000,
  parameter int BLANK_CICLOS = 16,
  parameter int LINHA_CIMA   = 0,
  parameter int LINHA_BAIXO  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilita,
  input  logic [2:0] posy,
  output logic [2:0] seletor_mux,
  output logic [7:0] linha,
  output logic       apagado,
  output logic       frame_fim
);

  localparam int MAX_CICLOS = (DWELL_CICLOS > BLANK_CICLOS) ? DWELL_CICLOS : BLANK_CICLOS;
  localparam int CW = $clog2(MAX_CICLOS + 1);
  localparam logic [CW-1:0] DWELL_ULT = CW'(DWELL_CICLOS - 1);
  localparam logic [CW-1:0] BLANK_ULT = CW'(BLANK_CICLOS - 1);
  localparam logic [2:0] SLOT_ULT = 3'd4;
  localparam logic [2:0] SLOT_BOLA = 3'd2;
  localparam logic [2:0] L_CIMA = 3'(LINHA_CIMA);
  localparam logic [2:0] L_BAIXO = 3'(LINHA_BAIXO);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox_estado;
  logic [2:0]    r_slot;
  logic [2:0]    w_prox_slot;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_prox_cnt;
  logic [2:0]    r_posy;
  logic [2:0]    w_prox_posy;
  logic [2:0]    w_idx;
  logic [7:0]    w_prox_linha;
  logic          w_prox_fim;

  logic [2:0]    r_seletor;
  logic [7:0]    r_linha;
  logic          r_apagado;
  logic          r_frame_fim;

  always_comb begin
    w_prox_estado = r_estado;
    w_prox_slot   = r_slot;
    w_prox_cnt    = r_cnt;
    case (r_estado)
      ST_IDLE: begin
        w_prox_slot = 3'd0;
        w_prox_cnt  = '0;
        if (habilita) w_prox_estado = ST_BLANK;
      end
      ST_BLANK: begin
        if (!habilita) begin
          w_prox_estado = ST_IDLE;
          w_prox_slot   = 3'd0;
          w_prox_cnt    = '0;
        end else if (r_cnt == BLANK_ULT) begin
          w_prox_estado = ST_ACTIVE;
          w_prox_cnt    = '0;
        end else begin
          w_prox_cnt = r_cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A lit slot always runs its full dwell, even when scanning is being stopped.
        if (r_cnt == DWELL_ULT) begin
          w_prox_cnt = '0;
          if (!habilita) begin
            w_prox_estado = ST_IDLE;
            w_prox_slot   = 3'd0;
          end else begin
            w_prox_estado = ST_BLANK;
            w_prox_slot   = (r_slot == SLOT_ULT) ? 3'd0 : r_slot + 3'd1;
          end
        end else begin
          w_prox_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_prox_estado = ST_IDLE;
        w_prox_slot   = 3'd0;
        w_prox_cnt    = '0;
      end
    endcase
  end

  // Ball line is captured once per frame, as the ball slot starts its blanking.
  always_comb begin
    w_prox_posy = r_posy;
    if (r_estado == ST_ACTIVE && w_prox_estado == ST_BLANK && w_prox_slot == SLOT_BOLA)
      w_prox_posy = posy;
  end

  always_comb begin
    case (w_prox_slot)
      3'd0, 3'd1: w_idx = L_CIMA;
      3'd2:       w_idx = r_posy;
      default:    w_idx = L_BAIXO;
    endcase
    w_prox_linha = (w_prox_estado == ST_ACTIVE) ? (8'd1 << w_idx) : 8'd0;
    w_prox_fim   = (w_prox_estado == ST_ACTIVE) && (w_prox_slot == SLOT_ULT) &&
                   (w_prox_cnt == DWELL_ULT);
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= ST_IDLE;
      r_slot      <= 3'd0;
      r_cnt       <= '0;
      r_posy      <= 3'd0;
      r_seletor   <= 3'd0;
      r_linha     <= 8'd0;
      r_apagado   <= 1'b1;
      r_frame_fim <= 1'b0;
    end else begin
      r_estado    <= w_prox_estado;
      r_slot      <= w_prox_slot;
      r_cnt       <= w_prox_cnt;
      r_posy      <= w_prox_posy;
      r_seletor   <= w_prox_slot;
      r_linha     <= w_prox_linha;
      r_apagado   <= (w_prox_linha == 8'd0);
      r_frame_fim <= w_prox_fim;
    end
  end

  assign seletor_mux = r_seletor;
  assign linha       = r_linha;
  assign apagado     = r_apagado;
  assign frame_fim   = r_frame_fim;

endmodule
